// File: rtl/adc_serial_responder.sv
// Serial ADC stand-in: answers a 3-wire master (adc_clk, adc_cs, adc_sd) with a
// frame of leading zeros followed by a sample, MSB first, shifted on adc_clk falls.
module adc_serial_responder #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LEAD_ZEROS   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    adc_clk,
  input  logic                    adc_cs,
  input  logic [1:0]              mode,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    adc_sd,
  output logic                    adc_sd_oe,
  output logic                    frame_done,
  output logic                    frame_abort,
  output logic [SAMPLE_WIDTH-1:0] sent_sample
);

  localparam int FRAME         = LEAD_ZEROS + SAMPLE_WIDTH;
  localparam int CW            = $clog2(FRAME);
  localparam int PW            = $clog2(SYNC_STAGES + 2);
  localparam int PRIME_MAX_INT = SYNC_STAGES + 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME - 1);
  localparam logic [PW-1:0] PRIME_MAX = PW'(PRIME_MAX_INT);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES:0]    clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES:0]    cs_sync_q, cs_sync_d;
  logic [PW-1:0]           prime_q, prime_d;
  logic [FRAME-1:0]        shreg_q, shreg_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] ramp_q, ramp_d;
  logic [SAMPLE_WIDTH-1:0] sent_q, sent_d;
  logic [1:0]              mode_q, mode_d;
  logic                    sd_q, sd_d;
  logic                    oe_q, oe_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  logic                    primed;
  logic                    sclk_fall, cs_fall, cs_rise;
  logic [SAMPLE_WIDTH-1:0] sel_value;

  // The top bit of each chain is edge history only; strobes compare the last two.
  // cs_fall is ignored until the whole chain has been refilled from the pin after
  // reset, so a cs already low at reset release never starts a frame.
  assign primed    = (prime_q == PRIME_MAX);
  assign sclk_fall = clk_sync_q[SYNC_STAGES] & ~clk_sync_q[SYNC_STAGES-1];
  assign cs_fall   = primed & cs_sync_q[SYNC_STAGES] & ~cs_sync_q[SYNC_STAGES-1];
  assign cs_rise   = ~cs_sync_q[SYNC_STAGES] & cs_sync_q[SYNC_STAGES-1];

  always_comb begin
    sel_value = sample_in;
    case (mode)
      2'd0: sel_value = sample_in;
      2'd1: sel_value = ramp_q;
      2'd2: sel_value = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
      2'd3: sel_value = {SAMPLE_WIDTH{1'b1}};
      default: sel_value = sample_in;
    endcase
  end

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-1:0], adc_clk};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-1:0], adc_cs};
    prime_d    = primed ? prime_q : prime_q + PW'(1);
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    ramp_d     = ramp_q;
    sent_d     = sent_q;
    mode_d     = mode_q;
    sd_d       = sd_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sd_d = 1'b0;
        oe_d = 1'b0;
        if (cs_fall) begin
          shreg_d   = {{LEAD_ZEROS{1'b0}}, sel_value};
          sent_d    = sel_value;
          mode_d    = mode;
          bit_cnt_d = '0;
          sd_d      = 1'b0;
          oe_d      = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall && bit_cnt_q == LAST_BIT) begin
          // Completion beats a simultaneous cs_rise: the frame is fully out.
          sd_d    = 1'b0;
          done_d  = 1'b1;
          if (mode_q == 2'd1) ramp_d = ramp_q + SAMPLE_WIDTH'(1);
          if (cs_rise) begin
            oe_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end else if (cs_rise) begin
          sd_d    = 1'b0;
          oe_d    = 1'b0;
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_fall) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          shreg_d   = {shreg_q[FRAME-2:0], 1'b0};
          sd_d      = shreg_q[FRAME-2];
        end
      end
      ST_DONE: begin
        sd_d = 1'b0;
        if (cs_rise) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sd_d    = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_sync_q <= '1;
      cs_sync_q  <= '1;
      prime_q    <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ramp_q     <= '0;
      sent_q     <= '0;
      mode_q     <= '0;
      sd_q       <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      cs_sync_q  <= cs_sync_d;
      prime_q    <= prime_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      ramp_q     <= ramp_d;
      sent_q     <= sent_d;
      mode_q     <= mode_d;
      sd_q       <= sd_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign adc_sd      = sd_q;
  assign adc_sd_oe   = oe_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign sent_sample = sent_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: a behavioural master clocks frames at clk/8 and
// checks captured bits, pulse counts and sent_sample against hand-computed values.
module tb_adc_serial_responder;

  logic        clk;
  logic        reset;
  logic        adc_clk;
  logic        adc_cs;
  logic [1:0]  mode;
  logic [11:0] sample_in;
  logic        adc_sd;
  logic        adc_sd_oe;
  logic        frame_done;
  logic        frame_abort;
  logic [11:0] sent_sample;

  int checks = 0;
  int failures = 0;
  int done_total = 0;
  int abort_total = 0;
  int snap_done = 0;
  int snap_abort = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] sample;
    logic [15:0] exp_cap;
  } vec_t;

  vec_t vecs[6];

  adc_serial_responder dut (
    .clk         (clk),
    .reset       (reset),
    .adc_clk     (adc_clk),
    .adc_cs      (adc_cs),
    .mode        (mode),
    .sample_in   (sample_in),
    .adc_sd      (adc_sd),
    .adc_sd_oe   (adc_sd_oe),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .sent_sample (sent_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done)  done_total  <= done_total + 1;
      if (frame_abort) abort_total <= abort_total + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic frame_begin();
    snap_done  = done_total;
    snap_abort = abort_total;
    adc_cs = 1'b0;
    tick(8);
  endtask

  // Sample before each fall: the bit on adc_sd is what the master saw at the preceding rise.
  task automatic clock_bits(input int n, input logic [31:0] cin, output logic [31:0] cout);
    cout = cin;
    for (int i = 0; i < n; i++) begin
      cout = {cout[30:0], adc_sd};
      adc_clk = 1'b0;
      tick(4);
      adc_clk = 1'b1;
      tick(4);
    end
  endtask

  task automatic frame_end(output int dones, output int aborts);
    adc_cs = 1'b1;
    tick(8);
    dones  = done_total - snap_done;
    aborts = abort_total - snap_abort;
  endtask

  initial begin
    logic [31:0] cap;
    int dn, ab;

    vecs[0] = '{mode: 2'd0, sample: 12'hA5C, exp_cap: 16'h0A5C};
    vecs[1] = '{mode: 2'd2, sample: 12'h3C3, exp_cap: 16'h0800};
    vecs[2] = '{mode: 2'd3, sample: 12'h000, exp_cap: 16'h0FFF};
    vecs[3] = '{mode: 2'd0, sample: 12'h000, exp_cap: 16'h0000};
    vecs[4] = '{mode: 2'd0, sample: 12'hFFF, exp_cap: 16'h0FFF};
    vecs[5] = '{mode: 2'd0, sample: 12'h5A1, exp_cap: 16'h05A1};

    reset = 1'b1;
    adc_clk = 1'b1;
    adc_cs = 1'b1;
    mode = 2'd0;
    sample_in = 12'h000;
    tick(3);
    check("rst_sd", {31'd0, adc_sd}, 32'd0);
    check("rst_oe", {31'd0, adc_sd_oe}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);
    check("rst_sent", {20'd0, sent_sample}, 32'd0);
    reset = 1'b0;
    tick(10);

    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      sample_in = vecs[i].sample;
      frame_begin();
      check("vec_oe_on", {31'd0, adc_sd_oe}, 32'd1);
      clock_bits(16, 32'd0, cap);
      frame_end(dn, ab);
      check("vec_cap", {16'd0, cap[15:0]}, {16'd0, vecs[i].exp_cap});
      check("vec_done", dn, 1);
      check("vec_abort", ab, 0);
      check("vec_sent", {20'd0, sent_sample}, {20'd0, vecs[i].exp_cap[11:0]});
      check("vec_oe_off", {31'd0, adc_sd_oe}, 32'd0);
    end

    // Ramp frames from reset: 0..4.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      frame_begin();
      clock_bits(16, 32'd0, cap);
      frame_end(dn, ab);
      check("ramp_cap", {16'd0, cap[15:0]}, i);
      check("ramp_done", dn, 1);
    end

    // Abort after 7 falls; ramp value must repeat on the next frame.
    frame_begin();
    clock_bits(7, 32'd0, cap);
    frame_end(dn, ab);
    check("abort_pulse", ab, 1);
    check("abort_nodone", dn, 0);
    check("abort_oe", {31'd0, adc_sd_oe}, 32'd0);
    check("abort_sent", {20'd0, sent_sample}, 32'd5);
    frame_begin();
    clock_bits(16, 32'd0, cap);
    frame_end(dn, ab);
    check("ramp_repeat", {16'd0, cap[15:0]}, 32'h0005);

    // 20 falls in mode 3: tail bits read zero, one frame_done.
    mode = 2'd3;
    frame_begin();
    clock_bits(20, 32'd0, cap);
    check("over_oe_held", {31'd0, adc_sd_oe}, 32'd1);
    frame_end(dn, ab);
    check("over_cap", {12'd0, cap[19:0]}, 32'h0FFF0);
    check("over_done", dn, 1);
    check("over_abort", ab, 0);

    // Mid-frame sample_in/mode change does not touch the frame in flight.
    mode = 2'd0;
    sample_in = 12'h123;
    frame_begin();
    clock_bits(6, 32'd0, cap);
    sample_in = 12'h456;
    mode = 2'd3;
    clock_bits(10, cap, cap);
    frame_end(dn, ab);
    check("chg_cap", {16'd0, cap[15:0]}, 32'h0123);
    check("chg_sent", {20'd0, sent_sample}, 32'h123);
    mode = 2'd0;
    frame_begin();
    clock_bits(16, 32'd0, cap);
    frame_end(dn, ab);
    check("chg_next", {16'd0, cap[15:0]}, 32'h0456);

    // Reset mid-frame with cs held low: no restart until a fresh cs fall.
    sample_in = 12'hABC;
    frame_begin();
    clock_bits(5, 32'd0, cap);
    reset = 1'b1;
    tick(2);
    check("mid_rst_oe", {31'd0, adc_sd_oe}, 32'd0);
    check("mid_rst_sent", {20'd0, sent_sample}, 32'd0);
    reset = 1'b0;
    tick(12);
    check("held_oe", {31'd0, adc_sd_oe}, 32'd0);
    clock_bits(4, 32'd0, cap);
    check("held_sd", {28'd0, cap[3:0]}, 32'd0);
    check("held_oe2", {31'd0, adc_sd_oe}, 32'd0);
    check("held_sent", {20'd0, sent_sample}, 32'd0);
    frame_end(dn, ab);
    check("held_done", dn, 0);
    frame_begin();
    clock_bits(16, 32'd0, cap);
    frame_end(dn, ab);
    check("post_rst_cap", {16'd0, cap[15:0]}, 32'h0ABC);
    check("post_rst_done", dn, 1);
    mode = 2'd1;
    frame_begin();
    clock_bits(16, 32'd0, cap);
    frame_end(dn, ab);
    check("post_rst_ramp", {16'd0, cap[15:0]}, 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
